// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: CPU load/store, UART write and RAM port signals of the data-RAM arbiter.
interface mips_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int UART_Nbit  = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [31:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_err;
    logic                  uart_req;
    logic [ADDR_WIDTH-1:0] uart_addr;
    logic [UART_Nbit-1:0]  uart_wdata;
    logic                  uart_gnt;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, uart_req, uart_addr, uart_wdata, ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, uart_gnt, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, uart_req, uart_addr, uart_wdata, ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err, uart_gnt, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares the data RAM between CPU lw/sw and UART byte writes, CPU first with starvation guard.
// Define ARB_ADDR_CHECK_EN to reject misaligned or out-of-segment CPU addresses.
module mips_mem_arbiter #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter int          UART_Nbit  = 8,
    parameter logic [31:0] DATA_BASE  = 32'h10010000,
    parameter int          MAX_WAIT   = 4
) (
    input logic clk,
    input logic reset,
    mips_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CPU_ACC, UART_ACC, RD_WAIT, RD_DONE} state_t;

    state_t                state, nxt;
    logic [3:0]            starve_cnt;
    logic                  ld_q, rej_q, cpu_pick, go_cpu, go_uart, bad;
    logic [ADDR_WIDTH-1:0] cpu_idx;

    // DATA_BASE is word aligned, so the word index is a subtraction on the index bits alone
    assign cpu_idx = bus.cpu_addr[ADDR_WIDTH+1:2] - DATA_BASE[ADDR_WIDTH+1:2];
`ifdef ARB_ADDR_CHECK_EN
    assign bad = (|bus.cpu_addr[1:0]) || (bus.cpu_addr < DATA_BASE) ||
                 ((bus.cpu_addr - DATA_BASE) >= (32'd4 << ADDR_WIDTH));
`else
    assign bad = 1'b0;
`endif
    assign cpu_pick = bus.cpu_req && !(bus.uart_req && starve_cnt == 4'(MAX_WAIT));
    assign go_cpu   = state == IDLE && cpu_pick;
    assign go_uart  = state == IDLE && !cpu_pick && bus.uart_req;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go_cpu ? CPU_ACC : go_uart ? UART_ACC : IDLE;
            CPU_ACC: nxt = ld_q ? RD_WAIT : IDLE;
            RD_WAIT: nxt = RD_DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_gnt    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_err    <= 1'b0;
            bus.uart_gnt   <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            starve_cnt     <= '0;
            ld_q           <= 1'b0;
            rej_q          <= 1'b0;
        end else begin
            bus.cpu_gnt    <= go_cpu;
            bus.cpu_err    <= go_cpu && bad;
            bus.uart_gnt   <= go_uart;
            bus.ram_we     <= go_uart || (go_cpu && bus.cpu_we && !bad);
            bus.cpu_rvalid <= state == RD_WAIT;
            if (go_cpu && !bad) begin
                bus.ram_addr  <= cpu_idx;
                bus.ram_wdata <= bus.cpu_wdata;
            end else if (go_uart) begin
                bus.ram_addr  <= bus.uart_addr;
                bus.ram_wdata <= DATA_WIDTH'(bus.uart_wdata);
            end
            if (go_cpu) begin
                ld_q  <= !bus.cpu_we;
                rej_q <= bad;
            end
            if (state == RD_WAIT) bus.cpu_rdata <= rej_q ? '0 : bus.ram_rdata;
            if (go_uart) starve_cnt <= '0;
            else if (go_cpu && bus.uart_req && starve_cnt != 4'(MAX_WAIT)) starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed checks of the data-RAM arbiter against a one-cycle-latency RAM model.
// Built with MAX_WAIT = 2 so the UART is forced through after two CPU grants.
module tb_mips_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pl_we = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .UART_Nbit(8)) bus ();

    mips_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .UART_Nbit(8),
                       .DATA_BASE(32'h10010000), .MAX_WAIT(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic test_reset;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.uart_req = 0; bus.uart_addr = '0; bus.uart_wdata = '0;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.uart_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.cpu_err !== 1'b0)
            begin errors++; $display("FAIL reset_pulses got gnt=%b ugnt=%b rv=%b err=%b exp 0", bus.cpu_gnt, bus.uart_gnt, bus.cpu_rvalid, bus.cpu_err); end
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h00 || bus.ram_wdata !== 32'h0 || bus.cpu_rdata !== 32'h0)
            begin errors++; $display("FAIL reset_ram got we=%b addr=%h wd=%h rd=%h exp 0", bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_rdata); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0)
            begin errors++; $display("FAIL idle_quiet got gnt=%b we=%b exp 0", bus.cpu_gnt, bus.ram_we); end
    endtask

    task automatic test_store;
        cpu_issue(1'b1, 32'h10010000, 32'h2C);
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h00 || bus.ram_wdata !== 32'h2C)
            begin errors++; $display("FAIL store_issue got gnt=%b we=%b addr=%h wd=%h exp 1 1 00 0000002c", bus.cpu_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 32'h2C)
            begin errors++; $display("FAIL store_after got gnt=%b we=%b wd=%h exp 0 0 0000002c", bus.cpu_gnt, bus.ram_we, bus.ram_wdata); end
        checks++; if (mem[0] !== 32'h2C)
            begin errors++; $display("FAIL store_ram got %h exp 0000002c", mem[0]); end
    endtask

    task automatic test_load;
        preload(8'h01, 32'h2A);
        cpu_issue(1'b0, 32'h10010004, 32'h0);
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h01)
            begin errors++; $display("FAIL load_issue got gnt=%b we=%b addr=%h exp 1 0 01", bus.cpu_gnt, bus.ram_we, bus.ram_addr); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h01)
            begin errors++; $display("FAIL load_wait got rv=%b we=%b addr=%h exp 0 0 01", bus.cpu_rvalid, bus.ram_we, bus.ram_addr); end
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h2A)
            begin errors++; $display("FAIL load_done got rv=%b rd=%h exp 1 0000002a", bus.cpu_rvalid, bus.cpu_rdata); end
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h2A)
            begin errors++; $display("FAIL load_hold got rv=%b rd=%h exp 0 0000002a", bus.cpu_rvalid, bus.cpu_rdata); end
    endtask

    task automatic test_uart;
        bus.uart_req = 1'b1; bus.uart_addr = 8'hF0; bus.uart_wdata = 8'h39;
        @(negedge clk);
        checks++; if (bus.uart_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'hF0 || bus.ram_wdata !== 32'h39)
            begin errors++; $display("FAIL uart_issue got ugnt=%b gnt=%b we=%b addr=%h wd=%h exp 1 0 1 f0 00000039", bus.uart_gnt, bus.cpu_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        bus.uart_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.uart_gnt !== 1'b0 || mem[8'hF0] !== 32'h39)
            begin errors++; $display("FAIL uart_after got ugnt=%b mem=%h exp 0 00000039", bus.uart_gnt, mem[8'hF0]); end
    endtask

    task automatic test_starvation;
        logic order [6];
        logic [5:0] exp_order = 6'b100100;
        int n = 0;
        cpu_issue(1'b1, 32'h10010008, 32'h11);
        bus.uart_req = 1'b1; bus.uart_addr = 8'h10; bus.uart_wdata = 8'h77;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_gnt || bus.uart_gnt) begin
                checks++; if (bus.cpu_gnt && bus.uart_gnt)
                    begin errors++; $display("FAIL starve_both got cpu=1 uart=1 exp one grant"); end
                if (bus.uart_gnt) begin
                    checks++; if (dut.starve_cnt !== 4'd0)
                        begin errors++; $display("FAIL starve_clear got %0d exp 0", dut.starve_cnt); end
                end
                order[n] = bus.uart_gnt;
                n++;
            end
        end
        bus.cpu_req = 1'b0; bus.uart_req = 1'b0;
        checks++; if (n != 6)
            begin errors++; $display("FAIL starve_count got %0d grants exp 6", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (order[i] !== exp_order[i])
                begin errors++; $display("FAIL starve_order grant %0d got uart=%b exp uart=%b", i, order[i], exp_order[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        cpu_issue(1'b1, 32'h1001000C, 32'hA1);
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 8'h03)
            begin errors++; $display("FAIL b2b_first got gnt=%b addr=%h exp 1 03", bus.cpu_gnt, bus.ram_addr); end
        bus.cpu_addr = 32'h10010010; bus.cpu_wdata = 32'hB2;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b0)
            begin errors++; $display("FAIL b2b_gap got gnt=%b exp 0", bus.cpu_gnt); end
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h04 || bus.ram_wdata !== 32'hB2)
            begin errors++; $display("FAIL b2b_second got gnt=%b we=%b addr=%h wd=%h exp 1 1 04 000000b2", bus.cpu_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_check;
        cpu_issue(1'b1, 32'h10020000, 32'hDEAD);
        @(negedge clk);
`ifdef ARB_ADDR_CHECK_EN
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.cpu_err !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h04)
            begin errors++; $display("FAIL addr_reject got gnt=%b err=%b we=%b addr=%h exp 1 1 0 04", bus.cpu_gnt, bus.cpu_err, bus.ram_we, bus.ram_addr); end
`else
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.cpu_err !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h00)
            begin errors++; $display("FAIL addr_wrap got gnt=%b err=%b we=%b addr=%h exp 1 0 1 00", bus.cpu_gnt, bus.cpu_err, bus.ram_we, bus.ram_addr); end
`endif
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_err !== 1'b0 || bus.cpu_gnt !== 1'b0)
            begin errors++; $display("FAIL addr_after got err=%b gnt=%b exp 0 0", bus.cpu_err, bus.cpu_gnt); end
    endtask

    task automatic test_reset_mid_load;
        int spurious = 0;
        int t = 0;
        preload(8'h05, 32'h55AA);
        cpu_issue(1'b0, 32'h10010014, 32'h99);
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.ram_addr !== 8'h05)
            begin errors++; $display("FAIL rst_load_issue got gnt=%b addr=%h exp 1 05", bus.cpu_gnt, bus.ram_addr); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.ram_addr !== 8'h00 || bus.ram_wdata !== 32'h0 || bus.cpu_gnt !== 1'b0 || bus.ram_we !== 1'b0)
            begin errors++; $display("FAIL rst_async got rv=%b rd=%h addr=%h wd=%h gnt=%b we=%b exp all 0", bus.cpu_rvalid, bus.cpu_rdata, bus.ram_addr, bus.ram_wdata, bus.cpu_gnt, bus.ram_we); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cpu_rvalid || bus.cpu_gnt) spurious++;
        end
        checks++; if (spurious != 0)
            begin errors++; $display("FAIL rst_abort got %0d stray pulses exp 0", spurious); end
        cpu_issue(1'b0, 32'h10010014, 32'h0);
        while (!bus.cpu_gnt && t < 10) begin @(negedge clk); t++; end
        bus.cpu_req = 1'b0;
        checks++; if (t != 1)
            begin errors++; $display("FAIL rst_fresh_gnt got latency %0d exp 1", t); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h55AA)
            begin errors++; $display("FAIL rst_fresh_load got rv=%b rd=%h exp 1 000055aa", bus.cpu_rvalid, bus.cpu_rdata); end
    endtask

    initial begin
        test_reset;
        test_store;
        test_load;
        test_uart;
        test_starvation;
        test_back_to_back;
        test_addr_check;
        test_reset_mid_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares the single-port data RAM of the multicycle MIPS core between two requesters: the CPU load/store path and the UART receive path, which writes received bytes into a RAM buffer.
- Translates CPU byte addresses (data segment at 0x10010000) to RAM word indices.
- Serialises accesses: one outstanding access at a time.
- CPU has priority, with bounded starvation protection for the UART.

Parameters:
- DATA_WIDTH, 32, RAM and CPU data width.
- ADDR_WIDTH, 8, RAM word-index width (2^ADDR_WIDTH words).
- UART_Nbit, 8, UART data width; zero-extended to DATA_WIDTH.
- DATA_BASE, 32'h10010000, CPU byte address that maps to RAM word 0.
- MAX_WAIT, 4, number of CPU grants allowed while the UART waits before the UART is forced through (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = store (sw), 0 = load (lw).
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_gnt  out  1  one-cycle pulse: CPU access issued to RAM.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_WIDTH  load data; held until the next load completes.
- cpu_err  out  1  one-cycle pulse on a rejected address (optional feature).
- uart_req  in  1  UART write request; held until uart_gnt.
- uart_addr  in  ADDR_WIDTH  RAM word index, used directly with no translation.
- uart_wdata  in  UART_Nbit  received byte.
- uart_gnt  out  1  one-cycle pulse: UART write issued.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM word index.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after ram_addr is presented.

Behaviour:
- States: IDLE, CPU_ACC, UART_ACC, RD_WAIT, RD_DONE. All outputs are registered.
- Reset: state = IDLE, starve_cnt = 0, and every output is 0 (including cpu_rdata and ram_addr).
- Reset asserted mid-access aborts the access: no gnt and no rvalid are produced afterwards.
- Arbitration in IDLE, evaluated at cycle N:
  - cpu_req && !(uart_req && starve_cnt == MAX_WAIT) -> CPU_ACC.
  - else uart_req -> UART_ACC.
  - else stay in IDLE.
- CPU_ACC (cycle N+1):
  - cpu_gnt = 1.
  - ram_addr = ((cpu_addr - DATA_BASE) >> 2) truncated to ADDR_WIDTH.
  - ram_we = cpu_we; ram_wdata = cpu_wdata.
  - Store: next state IDLE.
  - Load: next state RD_WAIT.
- RD_WAIT (N+2): ram_we = 0, ram_addr held. ram_rdata is captured into cpu_rdata at the end of the cycle.
- RD_DONE (N+3): cpu_rvalid = 1. Next state IDLE.
- Latency: store is 1 cycle from request to write; load is 3 cycles from request to cpu_rvalid.
- UART_ACC (N+1):
  - uart_gnt = 1, ram_we = 1, ram_addr = uart_addr.
  - ram_wdata = {zeros, uart_wdata}.
  - Next state IDLE.
- ram_we is 0 in every state except a CPU_ACC store or UART_ACC. ram_addr and ram_wdata hold their last values when idle.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, on each CPU grant issued while uart_req = 1.
  - Clears to 0 on each UART grant.
- Request rules:
  - A requester must deassert req in the cycle after gnt, or req is treated as a new request.
  - A request arriving while busy waits; it is never dropped.
- Simultaneous requests with starve_cnt < MAX_WAIT: CPU wins.
- Back-to-back accesses: a new grant is possible in the cycle immediately after a return to IDLE, with no idle bubble beyond the IDLE evaluation cycle.

Optional Feature:
- Macro: ARB_ADDR_CHECK_EN.
- When defined, a CPU access is rejected if cpu_addr is misaligned (cpu_addr[1:0] != 0) or lies outside [DATA_BASE, DATA_BASE + 4*2^ADDR_WIDTH). On rejection:
  - cpu_gnt and cpu_err pulse together in CPU_ACC.
  - ram_we = 0 and ram_addr is unchanged.
  - A rejected load still produces cpu_rvalid at N+3, with cpu_rdata = 0.
- When not defined: cpu_err is tied to 0 and out-of-range addresses wrap modulo 2^ADDR_WIDTH words.

Test Plan:
- Store: sw with cpu_addr = 0x10010000, wdata = 0x2C -> at N+1: cpu_gnt = 1, ram_we = 1, ram_addr = 0x00, ram_wdata = 0x0000002C; state is IDLE at N+2.
- Load: RAM word 1 preloaded with 0x2A, lw at 0x10010004 -> ram_addr = 0x01 at N+1 with ram_we = 0; cpu_rvalid pulses at N+3 with cpu_rdata = 0x0000002A.
- UART write: uart_addr = 0xF0, byte 0x39 -> uart_gnt at N+1, ram_we = 1, ram_addr = 0xF0, ram_wdata = 0x00000039.
- Starvation, MAX_WAIT = 2: cpu_req and uart_req held high continuously -> grant order CPU, CPU, UART, CPU, CPU, UART; starve_cnt returns to 0 after each UART grant.
- Reset asserted during RD_WAIT -> all outputs 0 immediately; no cpu_rvalid after release; a fresh lw completes normally.
- With ARB_ADDR_CHECK_EN defined: sw at 0x10020000 -> cpu_gnt and cpu_err pulse, ram_we stays 0. Without the macro: ram_we = 1, ram_addr = 0x00 (wraps).
